// File: rtl/btb_assoc.sv
// Fully-associative branch target buffer: combinational fetch lookup, execute-stage
// training with saturating direction counters, round-robin replacement, registered mispredict pulse.
module btb_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 4,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic [ADDR_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i,
  input  logic                  upd_pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target_i,
  output logic                  pred_hit_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o,
  output logic                  pred_error_o
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_ONE << (CNT_WIDTH - 1);

  logic [ENTRIES-1:0]    valid_r;
  logic [ADDR_WIDTH-1:0] tag_r    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_r [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_r    [ENTRIES];
  logic [PTR_W-1:0]      ptr_r;
  logic                  pred_error_r;

  logic [ENTRIES-1:0]    look_match_s;
  logic [ENTRIES-1:0]    upd_match_s;
  logic [PTR_W-1:0]      look_idx_s;
  logic [PTR_W-1:0]      upd_idx_s;
  logic [PTR_W-1:0]      free_idx_s;
  logic [PTR_W-1:0]      alloc_idx_s;
  logic                  look_hit_s;
  logic                  upd_hit_s;
  logic                  has_free_s;
  logic                  upd_error_s;

  // Priority encoder: lowest set bit wins (scan from the top so lower indices override).
  function automatic logic [PTR_W-1:0] lowest_idx(input logic [ENTRIES-1:0] vec);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      idx = vec[i] ? PTR_W'(i) : idx;
    end
    return idx;
  endfunction

  // Tag compare for both the fetch port and the update port.
  always_comb begin
    look_match_s = {ENTRIES{1'b0}};
    upd_match_s  = {ENTRIES{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      look_match_s[i] = valid_r[i] && (tag_r[i] == pc_i);
      upd_match_s[i]  = valid_r[i] && (tag_r[i] == upd_pc_i);
    end
  end

  // Entry selection and mispredict classification.
  always_comb begin
    look_hit_s  = |look_match_s;
    upd_hit_s   = |upd_match_s;
    has_free_s  = ~&valid_r;
    look_idx_s  = lowest_idx(look_match_s);
    upd_idx_s   = lowest_idx(upd_match_s);
    free_idx_s  = lowest_idx(~valid_r);
    alloc_idx_s = has_free_s ? free_idx_s : ptr_r;
    upd_error_s = (upd_taken_i != upd_pred_taken_i) ||
                  (upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i));
  end

  // Prediction outputs are zero-latency from the current table state.
  always_comb begin
    pred_hit_o    = look_hit_s;
    pred_taken_o  = look_hit_s && cnt_r[look_idx_s][CNT_WIDTH-1];
    pred_target_o = pred_taken_o ? target_r[look_idx_s] : {ADDR_WIDTH{1'b0}};
    pred_error_o  = pred_error_r;
  end

  // Mispredict pulse: evaluated for every update, independent of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_error_r <= 1'b0;
    end else begin
      pred_error_r <= upd_valid_i && upd_error_s;
    end
  end

  // Table training, allocation and replacement; flush overrides any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {ENTRIES{1'b0}};
      ptr_r   <= {PTR_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= {ADDR_WIDTH{1'b0}};
        target_r[i] <= {ADDR_WIDTH{1'b0}};
        cnt_r[i]    <= CNT_ZERO;
      end
    end else if (flush_i) begin
      valid_r <= {ENTRIES{1'b0}};
      ptr_r   <= {PTR_W{1'b0}};
    end else if (upd_valid_i) begin
      if (upd_hit_s) begin
        if (upd_taken_i) begin
          cnt_r[upd_idx_s]    <= (cnt_r[upd_idx_s] == CNT_MAX) ? CNT_MAX : cnt_r[upd_idx_s] + CNT_ONE;
          target_r[upd_idx_s] <= upd_target_i;
        end else begin
          cnt_r[upd_idx_s]    <= (cnt_r[upd_idx_s] == CNT_ZERO) ? CNT_ZERO : cnt_r[upd_idx_s] - CNT_ONE;
        end
      end else if (upd_taken_i) begin
        valid_r[alloc_idx_s]  <= 1'b1;
        tag_r[alloc_idx_s]    <= upd_pc_i;
        target_r[alloc_idx_s] <= upd_target_i;
        cnt_r[alloc_idx_s]    <= CNT_WEAK;
        if (!has_free_s) begin
          ptr_r <= ptr_r + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc: stimulus pushes expected lookup/error values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_btb_assoc;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic          flush_i = 1'b0;
  logic          upd_valid_i = 1'b0;
  logic [AW-1:0] upd_pc_i = '0;
  logic [AW-1:0] upd_target_i = '0;
  logic          upd_taken_i = 1'b0;
  logic          upd_pred_taken_i = 1'b0;
  logic [AW-1:0] upd_pred_target_i = '0;
  logic          pred_hit_o;
  logic          pred_taken_o;
  logic [AW-1:0] pred_target_o;
  logic          pred_error_o;

  btb_assoc #(.ADDR_WIDTH(AW), .ENTRIES(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .flush_i(flush_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_taken_i(upd_taken_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .pred_error_o(pred_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          hit;
    logic          taken;
    logic [AW-1:0] target;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Monitor: compare DUT outputs against the oldest expectation when a check is requested.
  always @(negedge clk) begin
    if (chk_req) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL monitor: check requested, got no expectation queued (want 1 entry)");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pred_hit_o !== e.hit || pred_taken_o !== e.taken ||
            pred_target_o !== e.target || pred_error_o !== e.err) begin
          fails++;
          $display("FAIL %s: got hit=%b taken=%b target=%h err=%b, want hit=%b taken=%b target=%h err=%b",
                   e.name, pred_hit_o, pred_taken_o, pred_target_o, pred_error_o,
                   e.hit, e.taken, e.target, e.err);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk,
                         input logic ptk, input logic [AW-1:0] ptgt);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_target_i      = tgt;
    upd_taken_i       = tk;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk,
                     input logic ptk, input logic [AW-1:0] ptgt);
    set_upd(pc, tgt, tk, ptk, ptgt);
    cyc();
    upd_valid_i = 1'b0;
  endtask

  // Present pc, queue the expected response, let the monitor sample this cycle.
  task automatic expect_look(input string name, input logic [AW-1:0] pc, input logic h,
                             input logic t, input logic [AW-1:0] tgt, input logic e);
    exp_t x;
    x.name = name; x.hit = h; x.taken = t; x.target = tgt; x.err = e;
    pc_i = pc;
    exp_q.push_back(x);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    expect_look("reset", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Allocate a taken branch predicted not-taken: error pulse then clears.
    upd(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    expect_look("alloc_err", 32'h100, 1'b1, 1'b1, 32'h200, 1'b1);
    expect_look("err_one_cycle", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);

    // Walk the counter down to zero and hold there.
    upd(32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_look("cnt_01", 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_look("cnt_00", 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_look("cnt_sat_low", 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 32'h280, 1'b1, 1'b0, 32'h0);
    expect_look("cnt_00_to_01", 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
    upd(32'h100, 32'h280, 1'b1, 1'b1, 32'h280);
    expect_look("cnt_10_new_tgt", 32'h100, 1'b1, 1'b1, 32'h280, 1'b0);
    upd(32'h100, 32'h280, 1'b1, 1'b1, 32'h280);
    upd(32'h100, 32'h280, 1'b1, 1'b1, 32'h280);
    upd(32'h100, 32'h0, 1'b0, 1'b1, 32'h280);
    expect_look("cnt_sat_high", 32'h100, 1'b1, 1'b1, 32'h280, 1'b1);

    // Flush, then fill and exercise round-robin replacement.
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    expect_look("flush_miss", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      upd(AW'(i * 16), AW'(32'h1000 + i * 16), 1'b1, 1'b1, AW'(32'h1000 + i * 16));
    end
    expect_look("fill_40", 32'h40, 1'b1, 1'b1, 32'h1040, 1'b0);
    upd(32'h50, 32'h1050, 1'b1, 1'b1, 32'h1050);
    expect_look("repl0_old_miss", 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_look("repl0_new_hit", 32'h50, 1'b1, 1'b1, 32'h1050, 1'b0);
    expect_look("repl0_keep_20", 32'h20, 1'b1, 1'b1, 32'h1020, 1'b0);
    upd(32'h60, 32'h1060, 1'b1, 1'b1, 32'h1060);
    expect_look("repl1_old_miss", 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_look("repl1_new_hit", 32'h60, 1'b1, 1'b1, 32'h1060, 1'b0);

    // Lookup concurrent with the update sees the old state.
    set_upd(32'h70, 32'h1070, 1'b1, 1'b1, 32'h1070);
    expect_look("same_cycle_old", 32'h70, 1'b0, 1'b0, 32'h0, 1'b0);
    upd_valid_i = 1'b0;
    expect_look("repl2_new_hit", 32'h70, 1'b1, 1'b1, 32'h1070, 1'b0);
    expect_look("repl2_old_miss", 32'h30, 1'b0, 1'b0, 32'h0, 1'b0);

    // Not-taken miss changes nothing, pointer stays at entry 3.
    upd(32'h90, 32'h1090, 1'b0, 1'b0, 32'h0);
    expect_look("nt_miss_no_alloc", 32'h90, 1'b0, 1'b0, 32'h0, 1'b0);
    upd(32'ha0, 32'h10a0, 1'b1, 1'b1, 32'h10a0);
    expect_look("repl3_old_miss", 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_look("repl3_keep_50", 32'h50, 1'b1, 1'b1, 32'h1050, 1'b0);

    // Target mispredict with correct direction, then a fully correct prediction.
    upd(32'h50, 32'h200, 1'b1, 1'b1, 32'h204);
    expect_look("tgt_err", 32'h50, 1'b1, 1'b1, 32'h200, 1'b1);
    upd(32'h50, 32'h200, 1'b1, 1'b1, 32'h200);
    expect_look("tgt_ok", 32'h50, 1'b1, 1'b1, 32'h200, 1'b0);

    // Flush beats a simultaneous allocation but the error pulse still fires.
    flush_i = 1'b1;
    upd(32'h300, 32'h400, 1'b1, 1'b0, 32'h0);
    flush_i = 1'b0;
    expect_look("flush_upd_miss", 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
    expect_look("flush_all_miss", 32'h50, 1'b0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    upd(32'h400, 32'h500, 1'b1, 1'b0, 32'h0);
    pc_i = 32'h400;
    #1;
    rst_n = 1'b0;
    expect_look("async_reset", 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    cyc();
    expect_look("after_reset_miss", 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);

    cyc();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
